perf_report_sched: RTL and testbench
====================================

# perf_report_sched

Scheduler that periodically snapshots the cache performance counters and serializes them as a framed byte stream to the UART transmitter. It sits between the event-counter block (L1I/L1D/L2 read, write and miss counts) and `uart_tx`. It replaces fixed-interval byte pushing with a real start/busy handshake, frame header, sequence number and checksum.

## Interface

**Parameters**
- `NCNT`, default 8: number of counters per frame.
- `CW`, default 16: counter width in bits; each counter is sent as 2 bytes, so `CW` ≤ 16 is required.
- `PERIOD`, default 50_000_000: clocks between automatic report requests; must be ≥ 2.
- `HDR`, default 8'hA5: frame header byte.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `trig_i` in 1: manual report request, one-cycle pulse.
- `cnt_i` in NCNT*CW: live counter values, flattened; counter k is `cnt_i[k*CW +: CW]`.
- `snap_o` out 1: one-cycle pulse when counters are captured; the counter block may clear on it.
- `tx_start_o` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data_o` out 8: byte for `uart_tx`, valid while `tx_start_o` is high.
- `tx_busy_i` in 1: `uart_tx` busy, from the cycle after start until the stop bit ends.
- `active_o` out 1: high while a frame is in progress (states other than IDLE).
- `overrun_o` out 1: sticky flag; a request was dropped.

## Operation

**Frame format**
- Bytes in order: `HDR`, `seq`, then for k = 0..NCNT-1: cnt[k][15:8], cnt[k][7:0], then `chk`.
- `chk` is the XOR of all preceding bytes in the frame, including `HDR`.
- Frame length is 2*NCNT + 3 bytes (19 at defaults).
- When `CW` < 16, counters are zero-extended to 16 bits.

**Sequence number**
- `seq` is 8 bits, reset to 0.
- Increments after the checksum byte completes; wraps 255→0.

**Request sources**
- `tick`: the period counter (0..PERIOD-1, free-running, wraps) pulses when it equals PERIOD-1.
- `trig_i`.
- When both arrive in the same cycle, they count as one request.

**State machine**
- IDLE: on a request or pending=1, go to SNAP and clear pending.
- SNAP (1 cycle): capture `cnt_i` into the shadow registers, pulse `snap_o`, clear byte index and checksum, then go to LOAD.
- LOAD: wait for `tx_busy_i`=0. Then drive `tx_data_o` with the current byte, pulse `tx_start_o`, fold the byte into the checksum, and go to WAIT_HI.
- WAIT_HI: wait for `tx_busy_i`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_busy_i`=0.
  - If the byte index is the last one, increment `seq` and go to IDLE.
  - Otherwise increment the index and go to LOAD.

**Requests while a frame is active**
- If pending=0, set pending; the next frame starts straight from IDLE.
- If pending=1, the request is dropped and `overrun_o` is set.
- `overrun_o` clears only on reset.

**Shadow registers**
- The shadow counters are the only source for data bytes.
- `cnt_i` changes after SNAP do not affect the frame in flight.

## Timing

**Reset values**
- `snap_o`=0, `tx_start_o`=0, `tx_data_o`=0, `active_o`=0, `overrun_o`=0.
- seq=0, period counter=0, pending=0, state=IDLE.

**Latency**
- Request seen in IDLE at edge t: `snap_o` is high in cycle t+1.
- The first `tx_start_o` follows one cycle after SNAP, provided `tx_busy_i`=0.

**Handshake**
- `tx_start_o` is never asserted while `tx_busy_i`=1.
- `tx_data_o` holds its value from the start pulse until the next LOAD.
- Minimum gap from one start to the next is 3 cycles (LOAD, WAIT_HI, WAIT_LO).

**Reset mid-frame**
- Outputs return immediately (asynchronously) to their reset values and the frame is abandoned.
- No checksum byte is emitted and `seq` is not incremented.

**Period counter**
- Runs in every state and is never restarted by a frame.

## Structure

**Package `perf_report_pkg`**
- State encoding: IDLE, SNAP, LOAD, WAIT_HI, WAIT_LO.
- Default `HDR`.
- Frame-length function of `NCNT`.
- Byte-index width function of `NCNT`.

**Sub-module `period_tick`**
- Parameterized by `PERIOD`.
- Has `clk` and `rstn`; produces the `tick` pulse.

**Top level**
- Holds the FSM, shadow registers, byte mux, checksum, seq, pending and overrun logic.

## Test plan

All scenarios use PERIOD=1000, NCNT=8, CW=16. The `uart_tx` model raises busy the cycle after start and holds it for 10 cycles.

1. Reset, then counters 0x0102, 0x0304, …, 0x0F10, then one `trig_i` pulse: expect 19 bytes A5, 00, 01, 02, …, 0F, 10, chk.
   - chk is the XOR of the preceding 18 bytes.
   - `snap_o` is high exactly once, one cycle after the trigger.
2. No trigger, run 2500 cycles: expect exactly two frames, starting at ticks 999 and 1999, with seq 00 then 01.
3. Change `cnt_i` on every cycle after SNAP: transmitted bytes equal the values captured at SNAP.
4. Two `trig_i` pulses during an active frame: expect exactly one follow-on frame and `overrun_o`=0. A third pulse in the same frame sets `overrun_o`=1, and it stays set.
5. Hold `tx_busy_i`=1 through SNAP: no `tx_start_o` until busy falls; then start follows on the next cycle.
6. Assert `rstn`=0 after byte 5: all outputs drop asynchronously. The next frame after release starts with A5, 00.

Source files
------------

// File: rtl/perf_report_pkg.sv
// Shared types and frame-geometry helpers for the performance-report scheduler.
package perf_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_LOAD,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Header + sequence + two bytes per counter + checksum.
    function automatic int unsigned frame_len(input int unsigned ncnt);
        return 2 * ncnt + 3;
    endfunction

    function automatic int unsigned idx_width(input int unsigned ncnt);
        return $clog2(2 * ncnt + 3);
    endfunction

endpackage

// File: rtl/perf_report_sched_period_tick.sv
// Free-running 0..PERIOD-1 counter that flags its terminal count, used as the
// automatic report request.
module period_tick
    import perf_report_pkg::*;
#(
    parameter int unsigned PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick_o
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/perf_report_sched.sv
// Snapshots the cache counters on a periodic tick or manual trigger and streams
// them to uart_tx as a header/seq/data/checksum frame over a start/busy handshake.
module perf_report_sched
    import perf_report_pkg::*;
#(
    parameter int unsigned NCNT   = 8,
    parameter int unsigned CW     = 16,
    parameter int unsigned PERIOD = 50_000_000,
    parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               trig_i,
    input  logic [NCNT*CW-1:0] cnt_i,
    output logic               snap_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    output logic               active_o,
    output logic               overrun_o
);

    localparam int unsigned FLEN = frame_len(NCNT);
    localparam int unsigned IW   = idx_width(NCNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    data_q, data_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   shadow_q [NCNT];
    logic [15:0]   shadow_d [NCNT];

    logic          tick;
    logic          req;
    logic [7:0]    frame_bytes [FLEN];
    logic [7:0]    cur_byte;

    period_tick #(.PERIOD(PERIOD)) u_period_tick (
        .clk    (clk),
        .rstn   (rstn),
        .tick_o (tick)
    );

    // A tick and a trigger in the same cycle collapse into one request.
    assign req = tick | trig_i;

    assign frame_bytes[0]      = HDR;
    assign frame_bytes[1]      = seq_q;
    assign frame_bytes[FLEN-1] = chk_q;

    generate
        for (genvar gi = 0; gi < NCNT; gi++) begin : g_bytes
            assign frame_bytes[2 + 2*gi] = shadow_q[gi][15:8];
            assign frame_bytes[3 + 2*gi] = shadow_q[gi][7:0];
        end
    endgenerate

    assign cur_byte = frame_bytes[idx_q];

    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            shadow_d[k] = (state_q == ST_SNAP) ? 16'(cnt_i[k*CW +: CW]) : shadow_q[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        seq_d      = seq_q;
        data_d     = data_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        snap_o     = 1'b0;
        tx_start_o = 1'b0;

        // One request may queue behind the running frame; a second is lost.
        if (state_q != ST_IDLE && req) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req || pending_q) begin
                    state_d   = ST_SNAP;
                    pending_d = 1'b0;
                end
            end
            ST_SNAP: begin
                snap_o  = 1'b1;
                idx_d   = '0;
                chk_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    data_d     = cur_byte;
                    chk_d      = chk_q ^ cur_byte;
                    state_d    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (idx_q == LAST_IDX) begin
                        seq_d   = seq_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The byte is presented combinationally during LOAD so it is valid with the start pulse.
    assign tx_data_o = (state_q == ST_LOAD) ? cur_byte : data_q;
    assign active_o  = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            chk_q     <= '0;
            seq_q     <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            seq_q     <= seq_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

endmodule

// File: tb/tb_perf_report_sched.sv
// Directed bench for perf_report_sched: a frame-level scoreboard checks every
// transmitted byte, plus literal expectations per scenario.
module tb_perf_report_sched;

    localparam int NCNT   = 8;
    localparam int CW     = 16;
    localparam int PERIOD = 1000;
    localparam int FLEN   = 2 * NCNT + 3;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               trig_i = 1'b0;
    logic [NCNT*CW-1:0] cnt_i = '0;
    logic               snap_o;
    logic               tx_start_o;
    logic [7:0]         tx_data_o;
    logic               tx_busy_i;
    logic               active_o;
    logic               overrun_o;

    logic busy_m = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy_i = busy_m | force_busy;

    always #5 clk = ~clk;

    perf_report_sched #(
        .NCNT   (NCNT),
        .CW     (CW),
        .PERIOD (PERIOD),
        .HDR    (8'hA5)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .trig_i     (trig_i),
        .cnt_i      (cnt_i),
        .snap_o     (snap_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_busy_i  (tx_busy_i),
        .active_o   (active_o),
        .overrun_o  (overrun_o)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cycle index since reset release: the cycle right after release is 0.
    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // uart_tx model: busy for 10 cycles starting the cycle after a start.
    int   busy_left = 0;
    logic uart_kick = 1'b0;
    always @(posedge clk) begin
        #1;
        if (uart_kick) begin
            busy_left = 10;
            uart_kick = 1'b0;
        end
        if (busy_left > 0) begin
            busy_m = 1'b1;
            busy_left--;
        end else begin
            busy_m = 1'b0;
        end
    end

    // Frame-level model: on capture, the whole expected frame is built from the
    // counter values present in that cycle and the model's own sequence number.
    logic [7:0] exp_b [FLEN];
    bit         frame_open = 1'b0;
    int         pos = 0;
    logic [7:0] mseq = 8'h00;
    int         snap_cnt = 0;
    int         start_cnt = 0;
    int         frames_done = 0;
    int         snap_log [$];
    int         start_cyc_log [$];
    logic [7:0] obs_log [$];
    logic [7:0] seq_log [$];

    always @(negedge clk) begin
        logic [7:0] chk;
        if (!rstn) begin
            frame_open = 1'b0;
            pos        = 0;
            mseq       = 8'h00;
        end else begin
            if (snap_o) begin
                check("snap_overlap", {31'b0, frame_open}, 32'd0);
                exp_b[0] = 8'hA5;
                exp_b[1] = mseq;
                for (int k = 0; k < NCNT; k++) begin
                    exp_b[2 + 2*k] = cnt_i[k*CW + 8 +: 8];
                    exp_b[3 + 2*k] = cnt_i[k*CW +: 8];
                end
                chk = 8'h00;
                for (int j = 0; j < FLEN - 1; j++) chk ^= exp_b[j];
                exp_b[FLEN-1] = chk;
                frame_open = 1'b1;
                pos = 0;
                snap_cnt++;
                snap_log.push_back(cyc);
            end
            if (tx_start_o) begin
                check("start_vs_busy", {31'b0, tx_busy_i}, 32'd0);
                check("start_in_frame", {31'b0, frame_open}, 32'd1);
                uart_kick = 1'b1;
                start_cnt++;
                start_cyc_log.push_back(cyc);
                obs_log.push_back(tx_data_o);
                if (frame_open) begin
                    check($sformatf("byte%0d", pos), {24'b0, tx_data_o}, {24'b0, exp_b[pos]});
                    pos++;
                    if (pos == FLEN) begin
                        frame_open = 1'b0;
                        mseq++;
                        frames_done++;
                        seq_log.push_back(exp_b[1]);
                    end
                end
            end
            if (frame_open) begin
                check("active", {31'b0, active_o}, 32'd1);
            end
        end
    end

    function automatic logic [7:0] obs_at(input int i);
        return (i < obs_log.size()) ? obs_log[i] : 8'hxx;
    endfunction

    function automatic int snap_at(input int i);
        return (i < snap_log.size()) ? snap_log[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        trig_i = 1'b0;
        force_busy = 1'b0;
        repeat (12) step();
        rstn = 1'b1;
    endtask

    task automatic pulse_trig(output int at_cyc);
        trig_i = 1'b1;
        at_cyc = cyc;
        step();
        trig_i = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        check(name, {31'b0, frames_done >= target}, 32'd1);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < NCNT; k++) cnt_i[k*CW +: CW] = {8'(2*k + 1), 8'(2*k + 2)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t, base, s0, f0, sl0, sq0, st0, sc0, r, n;

        // Reset state
        rstn = 1'b0;
        repeat (3) step();
        check("rst_snap",    {31'b0, snap_o},     32'd0);
        check("rst_start",   {31'b0, tx_start_o}, 32'd0);
        check("rst_data",    {24'b0, tx_data_o},  32'd0);
        check("rst_active",  {31'b0, active_o},   32'd0);
        check("rst_overrun", {31'b0, overrun_o},  32'd0);

        // 1: single triggered frame with a ramp pattern
        do_reset();
        load_ramp();
        base = obs_log.size(); s0 = snap_cnt; f0 = frames_done; sl0 = snap_log.size();
        step(); step();
        pulse_trig(t);
        wait_frames(f0 + 1, 400, "t1_done");
        repeat (20) step();
        check("t1_snap_count", snap_cnt - s0, 32'd1);
        check("t1_snap_cycle", snap_at(sl0), t + 1);
        check("t1_len", obs_log.size() - base, FLEN);
        check("t1_b0",  {24'b0, obs_at(base)},      32'hA5);
        check("t1_b1",  {24'b0, obs_at(base + 1)},  32'h00);
        check("t1_b2",  {24'b0, obs_at(base + 2)},  32'h01);
        check("t1_b17", {24'b0, obs_at(base + 17)}, 32'h10);
        check("t1_chk", {24'b0, obs_at(base + 18)}, 32'hB5);

        // 2: periodic frames only
        do_reset();
        s0 = snap_cnt; f0 = frames_done; sl0 = snap_log.size(); sq0 = seq_log.size();
        repeat (2500) step();
        check("t2_snap_count", snap_cnt - s0, 32'd2);
        check("t2_snap0", snap_at(sl0),     32'd1000);
        check("t2_snap1", snap_at(sl0 + 1), 32'd2000);
        check("t2_frames", frames_done - f0, 32'd2);
        check("t2_seq0", (sq0 < seq_log.size())     ? {24'b0, seq_log[sq0]}     : 32'hFFFF, 32'h00);
        check("t2_seq1", (sq0 + 1 < seq_log.size()) ? {24'b0, seq_log[sq0 + 1]} : 32'hFFFF, 32'h01);

        // 3: counters churn every cycle after capture
        do_reset();
        for (int k = 0; k < NCNT; k++) cnt_i[k*CW +: CW] = {8'(8'hC0 + k), 8'(8'hD0 + k)};
        base = obs_log.size(); f0 = frames_done;
        pulse_trig(t);
        n = 0;
        while (frames_done < f0 + 1 && n < 400) begin
            step();
            for (int k = 0; k < NCNT; k++) cnt_i[k*CW +: CW] = 16'($urandom);
            n++;
        end
        check("t3_done", {31'b0, frames_done >= f0 + 1}, 32'd1);
        check("t3_b2",  {24'b0, obs_at(base + 2)},  32'hC0);
        check("t3_b3",  {24'b0, obs_at(base + 3)},  32'hD0);
        check("t3_b16", {24'b0, obs_at(base + 16)}, 32'hC7);
        check("t3_b17", {24'b0, obs_at(base + 17)}, 32'hD7);
        check("t3_chk", {24'b0, obs_at(base + 18)}, 32'hA5);

        // 4a: one extra request during a frame queues exactly one follow-on frame
        do_reset();
        load_ramp();
        s0 = snap_cnt; f0 = frames_done;
        pulse_trig(t);
        repeat (40) step();
        pulse_trig(t);
        wait_frames(f0 + 2, 800, "t4a_done");
        repeat (200) step();
        check("t4a_snaps",   snap_cnt - s0,    32'd2);
        check("t4a_frames",  frames_done - f0, 32'd2);
        check("t4a_overrun", {31'b0, overrun_o}, 32'd0);

        // 4b: a second extra request in the same frame is dropped and flagged
        do_reset();
        s0 = snap_cnt; f0 = frames_done;
        pulse_trig(t);
        repeat (40) step();
        pulse_trig(t);
        repeat (40) step();
        check("t4b_ovr_before", {31'b0, overrun_o}, 32'd0);
        pulse_trig(t);
        check("t4b_ovr_set", {31'b0, overrun_o}, 32'd1);
        wait_frames(f0 + 2, 800, "t4b_done");
        repeat (200) step();
        check("t4b_snaps",  snap_cnt - s0,    32'd2);
        check("t4b_frames", frames_done - f0, 32'd2);
        check("t4b_ovr_sticky", {31'b0, overrun_o}, 32'd1);

        // 5: busy held through capture delays the first start
        do_reset();
        load_ramp();
        force_busy = 1'b1;
        s0 = snap_cnt; f0 = frames_done; st0 = start_cnt; sc0 = start_cyc_log.size(); sl0 = snap_log.size();
        pulse_trig(t);
        repeat (20) step();
        check("t5_no_start", start_cnt - st0, 32'd0);
        check("t5_snap_cycle", snap_at(sl0), t + 1);
        force_busy = 1'b0;
        r = cyc;
        wait_frames(f0 + 1, 400, "t5_done");
        check("t5_first_start", (sc0 < start_cyc_log.size()) ? start_cyc_log[sc0] : -1, r);

        // 6: reset in the middle of a frame
        do_reset();
        load_ramp();
        f0 = frames_done; st0 = start_cnt;
        pulse_trig(t);
        n = 0;
        while (start_cnt < st0 + 5 && n < 200) begin
            step();
            n++;
        end
        check("t6_five_bytes", start_cnt - st0, 32'd5);
        check("t6_active_pre", {31'b0, active_o}, 32'd1);
        check("t6_data_pre", {24'b0, tx_data_o}, 32'h03);
        rstn = 1'b0;
        #1;
        check("t6_snap",    {31'b0, snap_o},     32'd0);
        check("t6_start",   {31'b0, tx_start_o}, 32'd0);
        check("t6_data",    {24'b0, tx_data_o},  32'd0);
        check("t6_active",  {31'b0, active_o},   32'd0);
        check("t6_overrun", {31'b0, overrun_o},  32'd0);
        repeat (12) step();
        rstn = 1'b1;
        repeat (3) step();
        check("t6_no_complete", frames_done - f0, 32'd0);
        base = obs_log.size();
        pulse_trig(t);
        wait_frames(f0 + 1, 400, "t6_done");
        check("t6_b0",  {24'b0, obs_at(base)},     32'hA5);
        check("t6_b1",  {24'b0, obs_at(base + 1)}, 32'h00);
        check("t6_len", obs_log.size() - base, FLEN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
